// File: rtl/dmem_responder_if.sv
// Load/store handshake between the MEM stage (master) and the data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_read;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall_o;

  modport master (
    output req_valid, req_read, req_write, req_addr, req_wdata,
    input  resp_valid, resp_rdata, resp_err, stall_o
  );

  modport slave (
    input  req_valid, req_read, req_write, req_addr, req_wdata,
    output resp_valid, resp_rdata, resp_err, stall_o
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle word-wide data memory behind the MEM stage: accepts one load/store,
// stalls the pipeline for WAIT_STATES cycles, then pulses a one-cycle response.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2,
  parameter int CNT_W       = 4
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_wdata;
  logic             r_read;
  logic             r_write;
  logic             r_err;
  logic [31:0]      r_resp_rdata;
  logic             r_resp_err;
  logic [31:0]      r_mem [DEPTH_WORDS];

  logic             w_accept;
  logic             w_req_err;
  logic             w_commit;
  logic             w_from_req;
  logic [IDX_W-1:0] w_c_idx;
  logic [31:0]      w_c_wdata;
  logic             w_c_read;
  logic             w_c_write;
  logic             w_c_err;

  assign w_accept  = (r_state == S_IDLE) && bus.req_valid && (bus.req_read || bus.req_write);
  assign w_req_err = (bus.req_addr[1:0] != 2'b00)
                  || (bus.req_addr[31:2] >= 30'(DEPTH_WORDS))
                  || (bus.req_read && bus.req_write);

  // With zero wait states the commit edge is the acceptance edge, so the live request is used.
  assign w_from_req = (r_state == S_IDLE);
  assign w_c_idx    = w_from_req ? bus.req_addr[IDX_W+1:2] : r_idx;
  assign w_c_wdata  = w_from_req ? bus.req_wdata : r_wdata;
  assign w_c_read   = w_from_req ? bus.req_read  : r_read;
  assign w_c_write  = w_from_req ? bus.req_write : r_write;
  assign w_c_err    = w_from_req ? w_req_err     : r_err;

  assign w_commit = !rst && (w_next_state == S_RESP) && (r_state != S_RESP);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
      S_WAIT:  if (r_cnt == CNT_W'(1)) w_next_state = S_RESP;
      S_RESP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_wdata      <= '0;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_err        <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_cnt   <= CNT_W'(WAIT_STATES);
        r_idx   <= bus.req_addr[IDX_W+1:2];
        r_wdata <= bus.req_wdata;
        r_read  <= bus.req_read;
        r_write <= bus.req_write;
        r_err   <= w_req_err;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_commit) begin
        r_resp_err <= w_c_err;
        if (w_c_err)       r_resp_rdata <= '0;
        else if (w_c_read) r_resp_rdata <= r_mem[w_c_idx];
      end
    end
  end

  // NOTE: the memory array has no reset; clearing it would need a per-word reset path and is not wanted.
  always_ff @(posedge clk) begin
    if (w_commit && w_c_write && !w_c_err) r_mem[w_c_idx] <= w_c_wdata;
  end

  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;
  assign bus.stall_o    = w_accept || (r_state == S_WAIT);
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: two instances (WAIT_STATES=2 and 0) against a
// word-array reference model with directed scenarios and randomized load/store traffic.
module tb_dmem_responder;
  localparam int DEPTH = 256;

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } op_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_responder_if bus2 ();
  dmem_responder_if bus0 ();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave));
  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave));

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] ref_mem   [2][DEPTH];
  logic [31:0] ref_rdata [2];

  // sel 1 -> WAIT_STATES=2 instance, sel 0 -> WAIT_STATES=0 instance
  task automatic drive(input int sel, input logic v, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel == 1) begin
      bus2.req_valid = v; bus2.req_read = r; bus2.req_write = w; bus2.req_addr = a; bus2.req_wdata = d;
    end else begin
      bus0.req_valid = v; bus0.req_read = r; bus0.req_write = w; bus0.req_addr = a; bus0.req_wdata = d;
    end
  endtask

  function automatic logic get_rv(input int sel);
    return (sel == 1) ? bus2.resp_valid : bus0.resp_valid;
  endfunction
  function automatic logic [31:0] get_rd(input int sel);
    return (sel == 1) ? bus2.resp_rdata : bus0.resp_rdata;
  endfunction
  function automatic logic get_err(input int sel);
    return (sel == 1) ? bus2.resp_err : bus0.resp_err;
  endfunction
  function automatic logic get_stall(input int sel);
    return (sel == 1) ? bus2.stall_o : bus0.stall_o;
  endfunction

  function automatic op_t mk(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    op_t o;
    o.r = r; o.w = w; o.a = a; o.d = d;
    return o;
  endfunction

  // Reference model: a word array plus the last returned load data, per instance.
  function automatic void model_access(input int sel, input op_t o,
                                       output logic exp_err, output logic [31:0] exp_rdata);
    exp_err = (o.a % 4 != 0) || (o.a >= 32'(4 * DEPTH)) || (o.r && o.w);
    if (exp_err)  ref_rdata[sel] = 32'h0;
    else if (o.w) ref_mem[sel][int'(o.a / 4)] = o.d;
    else          ref_rdata[sel] = ref_mem[sel][int'(o.a / 4)];
    exp_rdata = ref_rdata[sel];
  endfunction

  function automatic int exp_lat(input int sel);
    return (sel == 1) ? 3 : 1;
  endfunction

  // Presents one request from an idle responder and follows it to its response.
  // After acceptance the request fields are scrambled; the responder must use its latched copy.
  task automatic run_access(input int sel, input op_t o, output int lat,
                            output logic [31:0] rdata, output logic err, output int hs_bad);
    lat = 99; rdata = '0; err = 1'b0; hs_bad = 0;
    @(posedge clk); #1;
    drive(sel, 1'b1, o.r, o.w, o.a, o.d);
    #1;
    if (get_stall(sel) !== 1'b1 || get_rv(sel) !== 1'b0) hs_bad++;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      drive(sel, 1'b1, o.r, o.w, $urandom, $urandom);
      #1;
      if (get_rv(sel) === 1'b1) begin
        lat = n; rdata = get_rd(sel); err = get_err(sel);
        if (get_stall(sel) !== 1'b0) hs_bad++;
        break;
      end else if (get_stall(sel) !== 1'b1) begin
        hs_bad++;
      end
    end
    drive(sel, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      n_checks++; if (get_rv(s) !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid[%0d]: got %b expected 0", s, get_rv(s)); end
      n_checks++; if (get_rd(s) !== 32'h0) begin n_fail++; $display("FAIL reset_resp_rdata[%0d]: got %h expected 0", s, get_rd(s)); end
      n_checks++; if (get_err(s) !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err[%0d]: got %b expected 0", s, get_err(s)); end
      n_checks++; if (get_stall(s) !== 1'b0) begin n_fail++; $display("FAIL reset_stall[%0d]: got %b expected 0", s, get_stall(s)); end
      ref_rdata[s] = 32'h0;
    end
    rst = 1'b0;
  endtask

  task automatic test_store_latency();
    int lat, hs; logic [31:0] rd; logic er; logic xe; logic [31:0] xd;
    op_t o = mk(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    run_access(1, o, lat, rd, er, hs);
    model_access(1, o, xe, xd);
    n_checks++; if (lat != 3) begin n_fail++; $display("FAIL store_latency: got %0d expected 3", lat); end
    n_checks++; if (hs != 0) begin n_fail++; $display("FAIL store_stall_pattern: got %0d bad cycles expected 0", hs); end
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL store_err: got %b expected 0", er); end
    n_checks++; if (rd !== xd) begin n_fail++; $display("FAIL store_rdata_unchanged: got %h expected %h", rd, xd); end
  endtask

  task automatic test_load_after_store();
    int lat, hs; logic [31:0] rd; logic er; logic xe; logic [31:0] xd;
    op_t o = mk(1'b1, 1'b0, 32'h10, 32'h0);
    run_access(1, o, lat, rd, er, hs);
    model_access(1, o, xe, xd);
    n_checks++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL raw_rdata: got %h expected deadbeef", rd); end
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL raw_err: got %b expected 0", er); end
    n_checks++; if (lat != 3) begin n_fail++; $display("FAIL raw_latency: got %0d expected 3", lat); end
    n_checks++; if (hs != 0) begin n_fail++; $display("FAIL raw_stall_pattern: got %0d bad cycles expected 0", hs); end
  endtask

  task automatic test_errors();
    op_t ops[$];
    ops.push_back(mk(1'b1, 1'b0, 32'h13,  32'h0));
    ops.push_back(mk(1'b1, 1'b0, 32'h400, 32'h0));
    ops.push_back(mk(1'b0, 1'b1, 32'h11,  32'h1111_1111));
    ops.push_back(mk(1'b0, 1'b1, 32'h400, 32'h2222_2222));
    ops.push_back(mk(1'b0, 1'b1, 32'h3FC, 32'hCAFE_F00D));
    ops.push_back(mk(1'b1, 1'b0, 32'h3FC, 32'h0));
    ops.push_back(mk(1'b1, 1'b0, 32'h10,  32'h0));
    foreach (ops[i]) begin
      int lat, hs; logic [31:0] rd; logic er; logic xe; logic [31:0] xd;
      run_access(1, ops[i], lat, rd, er, hs);
      model_access(1, ops[i], xe, xd);
      n_checks++; if (er !== xe) begin n_fail++; $display("FAIL err_case%0d_err: got %b expected %b", i, er, xe); end
      n_checks++; if (rd !== xd) begin n_fail++; $display("FAIL err_case%0d_rdata: got %h expected %h", i, rd, xd); end
      n_checks++; if (lat != 3) begin n_fail++; $display("FAIL err_case%0d_latency: got %0d expected 3", i, lat); end
    end
  endtask

  task automatic test_reset_mid_access();
    int lat, hs, hits; logic [31:0] rd; logic er; logic xe; logic [31:0] xd;
    op_t o = mk(1'b0, 1'b1, 32'h20, 32'hAAAA_5555);
    run_access(1, o, lat, rd, er, hs);
    model_access(1, o, xe, xd);
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL rst_pre_store_err: got %b expected 0", er); end
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b0, 1'b1, 32'h20, 32'h1234_5678);
    @(posedge clk); #1;
    n_checks++; if (get_stall(1) !== 1'b1) begin n_fail++; $display("FAIL rst_in_wait_stall: got %b expected 1", get_stall(1)); end
    rst = 1'b1;
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    n_checks++; if (get_rv(1) !== 1'b0) begin n_fail++; $display("FAIL rst_mid_resp_valid: got %b expected 0", get_rv(1)); end
    n_checks++; if (get_rd(1) !== 32'h0) begin n_fail++; $display("FAIL rst_mid_rdata: got %h expected 0", get_rd(1)); end
    n_checks++; if (get_err(1) !== 1'b0) begin n_fail++; $display("FAIL rst_mid_err: got %b expected 0", get_err(1)); end
    n_checks++; if (get_stall(1) !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall: got %b expected 0", get_stall(1)); end
    rst = 1'b0;
    ref_rdata[0] = 32'h0;
    ref_rdata[1] = 32'h0;
    hits = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (get_rv(1) !== 1'b0) hits++;
    end
    n_checks++; if (hits != 0) begin n_fail++; $display("FAIL rst_no_late_resp: got %0d responses expected 0", hits); end
    o = mk(1'b1, 1'b0, 32'h20, 32'h0);
    run_access(1, o, lat, rd, er, hs);
    model_access(1, o, xe, xd);
    n_checks++; if (rd !== 32'hAAAA_5555) begin n_fail++; $display("FAIL rst_store_dropped: got %h expected aaaa5555", rd); end
  endtask

  task automatic test_back_to_back();
    int lat, hs; logic [31:0] rd; logic er; logic xe; logic [31:0] xd0, xd1;
    op_t p0 = mk(1'b0, 1'b1, 32'h0, 32'h0123_4567);
    op_t p1 = mk(1'b0, 1'b1, 32'h4, 32'h89AB_CDEF);
    run_access(0, p0, lat, rd, er, hs); model_access(0, p0, xe, xd0);
    run_access(0, p1, lat, rd, er, hs); model_access(0, p1, xe, xd0);
    model_access(0, mk(1'b1, 1'b0, 32'h0, 32'h0), xe, xd0);
    model_access(0, mk(1'b1, 1'b0, 32'h4, 32'h0), xe, xd1);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0); #1;
    n_checks++; if (get_stall(0) !== 1'b1 || get_rv(0) !== 1'b0) begin n_fail++; $display("FAIL b2b_T: got stall=%b rv=%b expected stall=1 rv=0", get_stall(0), get_rv(0)); end
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 1'b0, 32'h4, 32'h0); #1;
    n_checks++; if (get_stall(0) !== 1'b0 || get_rv(0) !== 1'b1) begin n_fail++; $display("FAIL b2b_T1: got stall=%b rv=%b expected stall=0 rv=1", get_stall(0), get_rv(0)); end
    n_checks++; if (get_rd(0) !== xd0) begin n_fail++; $display("FAIL b2b_T1_rdata: got %h expected %h", get_rd(0), xd0); end
    @(posedge clk); #2;
    n_checks++; if (get_stall(0) !== 1'b1 || get_rv(0) !== 1'b0) begin n_fail++; $display("FAIL b2b_T2: got stall=%b rv=%b expected stall=1 rv=0", get_stall(0), get_rv(0)); end
    @(posedge clk); #2;
    n_checks++; if (get_stall(0) !== 1'b0 || get_rv(0) !== 1'b1) begin n_fail++; $display("FAIL b2b_T3: got stall=%b rv=%b expected stall=0 rv=1", get_stall(0), get_rv(0)); end
    n_checks++; if (get_rd(0) !== xd1) begin n_fail++; $display("FAIL b2b_T3_rdata: got %h expected %h", get_rd(0), xd1); end
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_bad_ops();
    int hits;
    op_t ops[$];
    ops.push_back(mk(1'b0, 1'b1, 32'h8, 32'h55AA_55AA));
    ops.push_back(mk(1'b1, 1'b1, 32'h8, 32'hFFFF_FFFF));
    ops.push_back(mk(1'b1, 1'b0, 32'h8, 32'h0));
    foreach (ops[i]) begin
      int lat, hs; logic [31:0] rd; logic er; logic xe; logic [31:0] xd;
      run_access(1, ops[i], lat, rd, er, hs);
      model_access(1, ops[i], xe, xd);
      n_checks++; if (er !== xe) begin n_fail++; $display("FAIL badop%0d_err: got %b expected %b", i, er, xe); end
      n_checks++; if (rd !== xd) begin n_fail++; $display("FAIL badop%0d_rdata: got %h expected %h", i, rd, xd); end
    end
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0);
    hits = 0;
    repeat (4) begin
      #1;
      if (get_stall(1) !== 1'b0 || get_rv(1) !== 1'b0) hits++;
      @(posedge clk); #1;
    end
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_checks++; if (hits != 0) begin n_fail++; $display("FAIL noop_ignored: got %0d active cycles expected 0", hits); end
  endtask

  task automatic test_random();
    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < 16; w++) begin
        int lat, hs; logic [31:0] rd; logic er; logic xe; logic [31:0] xd;
        op_t o = mk(1'b0, 1'b1, 32'(w * 4), $urandom);
        run_access(s, o, lat, rd, er, hs);
        model_access(s, o, xe, xd);
      end
      for (int i = 0; i < 60; i++) begin
        int lat, hs; logic [31:0] rd; logic er; logic xe; logic [31:0] xd;
        op_t o;
        int kind = $urandom_range(0, 9);
        logic rnw = 1'($urandom_range(0, 1));
        logic [31:0] a = 32'($urandom_range(0, 15) * 4);
        case (kind)
          0:       o = mk(rnw, !rnw, a | 32'($urandom_range(1, 3)), $urandom);
          1:       o = mk(rnw, !rnw, ($urandom | 32'h400) & 32'hFFFF_FFFC, $urandom);
          2:       o = mk(1'b1, 1'b1, a, $urandom);
          default: o = mk(rnw, !rnw, a, $urandom);
        endcase
        run_access(s, o, lat, rd, er, hs);
        model_access(s, o, xe, xd);
        n_checks++; if (er !== xe) begin n_fail++; $display("FAIL rnd%0d_%0d_err: got %b expected %b addr %h", s, i, er, xe, o.a); end
        n_checks++; if (rd !== xd) begin n_fail++; $display("FAIL rnd%0d_%0d_rdata: got %h expected %h addr %h", s, i, rd, xd, o.a); end
        n_checks++; if (lat != exp_lat(s)) begin n_fail++; $display("FAIL rnd%0d_%0d_latency: got %0d expected %0d", s, i, lat, exp_lat(s)); end
        n_checks++; if (hs != 0) begin n_fail++; $display("FAIL rnd%0d_%0d_stall: got %0d bad cycles expected 0", s, i, hs); end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_latency();
    test_load_after_store();
    test_errors();
    test_reset_mid_access();
    test_back_to_back();
    test_bad_ops();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
